// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - ID-stage branch unit with per-PC saturating-counter BHT
module branch_predictor_bht #(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CTR_BITS   = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bht_clear,
  input  logic [INST_WIDTH-1:0] inst_IF_ID,
  input  logic [XLEN-1:0]       PC_IF_ID,
  input  logic [XLEN-1:0]       rs1_data,
  output logic                  branch_taken,
  output logic                  branch_source,
  output logic [XLEN-1:0]       branch_jalr_target,
  output logic [XLEN-1:0]       branch_jal_beq_bne_target,
  output logic                  pred_taken,
  output logic                  busy,
  input  logic                  resolve_valid,
  input  logic [XLEN-1:0]       resolve_pc,
  input  logic                  resolve_taken,
  input  logic                  resolve_pred_taken,
  input  logic [XLEN-1:0]       resolve_target,
  output logic                  mispredict,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [STAT_WIDTH-1:0] pred_cnt,
  output logic [STAT_WIDTH-1:0] mispred_cnt
);

  localparam int IDX_BITS = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [IDX_BITS-1:0] PTR_LAST = IDX_BITS'(BHT_DEPTH - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_INIT   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_BITS-1:0] ptr;
  logic [CTR_BITS-1:0] bht [BHT_DEPTH];

  logic [6:0]          opcode;
  logic [XLEN-1:0]     imm_i;
  logic [XLEN-1:0]     imm_j;
  logic [XLEN-1:0]     imm_b;
  logic [XLEN-1:0]     jalr_sum;
  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic                bht_msb;
  logic                is_branch;

  assign opcode   = inst_IF_ID[6:0];
  assign imm_i    = {{(XLEN-12){inst_IF_ID[31]}}, inst_IF_ID[31:20]};
  assign imm_j    = {{(XLEN-21){inst_IF_ID[31]}}, inst_IF_ID[31], inst_IF_ID[19:12],
                     inst_IF_ID[20], inst_IF_ID[30:21], 1'b0};
  assign imm_b    = {{(XLEN-13){inst_IF_ID[31]}}, inst_IF_ID[31], inst_IF_ID[7],
                     inst_IF_ID[30:25], inst_IF_ID[11:8], 1'b0};
  assign jalr_sum = rs1_data + imm_i;
  assign rd_idx   = PC_IF_ID[IDX_BITS+1:2];
  assign upd_idx  = resolve_pc[IDX_BITS+1:2];
  // Stored value only: a same-cycle update to this index shows up next cycle.
  assign bht_msb  = bht[rd_idx][CTR_BITS-1];
  assign busy     = (state == S_INIT);
  assign is_branch = (state == S_ACTIVE) && (opcode == OP_BR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a clear request always wins and (re)starts the sweep.
  always_comb begin
    state_next = state;
    if (bht_clear) begin
      state_next = S_INIT;
    end else begin
      case (state)
        S_IDLE:   state_next = start ? S_ACTIVE : S_IDLE;
        S_ACTIVE: state_next = start ? S_ACTIVE : S_IDLE;
        S_INIT:   if (ptr == PTR_LAST) state_next = start ? S_ACTIVE : S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Sweep pointer: one entry per INIT cycle, rewound by every clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (bht_clear) begin
      ptr <= '0;
    end else if (state == S_INIT) begin
      ptr <= ptr + IDX_BITS'(1);
    end
  end

  // Counter table: sweep writes in INIT, otherwise saturating resolution updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (state == S_INIT) begin
      bht[ptr] <= CTR_INIT;
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (bht[upd_idx] != CTR_MAX) bht[upd_idx] <= bht[upd_idx] + CTR_BITS'(1);
      end else begin
        if (bht[upd_idx] != '0) bht[upd_idx] <= bht[upd_idx] - CTR_BITS'(1);
      end
    end
  end

  // Decode and target generation; everything stays quiet outside ACTIVE.
  always_comb begin
    branch_taken              = 1'b0;
    branch_source             = 1'b0;
    branch_jalr_target        = '0;
    branch_jal_beq_bne_target = '0;
    pred_taken                = 1'b0;
    if (state == S_ACTIVE) begin
      case (opcode)
        OP_JAL: begin
          branch_taken              = 1'b1;
          branch_jal_beq_bne_target = PC_IF_ID + imm_j;
        end
        OP_JALR: begin
          branch_taken       = 1'b1;
          branch_source      = 1'b1;
          branch_jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
        end
        OP_BR: begin
          branch_taken              = bht_msb;
          pred_taken                = bht_msb;
          branch_jal_beq_bne_target = PC_IF_ID + imm_b;
        end
        default: ;
      endcase
    end
  end

  // Mispredict detection from EX is independent of the local state.
  always_comb begin
    mispredict  = resolve_valid & (resolve_taken != resolve_pred_taken);
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);
    end
  end

  // Saturating statistics, counted only while ACTIVE and kept across clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_cnt    <= '0;
      mispred_cnt <= '0;
    end else if (state == S_ACTIVE) begin
      if (is_branch && pred_cnt != STAT_MAX) pred_cnt <= pred_cnt + STAT_WIDTH'(1);
      if (mispredict && mispred_cnt != STAT_MAX) mispred_cnt <= mispred_cnt + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed vector bench for branch_predictor_bht
module tb_branch_predictor_bht;

  localparam int SW    = 5;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] BEQ8   = 32'h00000463;
  localparam logic [31:0] JAL_M8 = 32'hFF9FF06F;

  logic          clk = 1'b0;
  logic          rst_n, start, bht_clear;
  logic [31:0]   inst, pc, rs1;
  logic          branch_taken, branch_source, pred_taken, busy;
  logic [31:0]   jalr_t, rel_t;
  logic          rv, rt, rpt;
  logic [31:0]   rpc, rtgt;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] pred_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;
  int exp_pc = 0;
  int exp_mc = 0;
  int n;
  logic quiet;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic        taken;
    logic        src;
    logic [31:0] jalr_t;
    logic [31:0] rel_t;
    logic        pred;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  branch_predictor_bht #(
    .XLEN(32), .INST_WIDTH(32), .BHT_DEPTH(DEPTH), .CTR_BITS(2), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bht_clear(bht_clear),
    .inst_IF_ID(inst), .PC_IF_ID(pc), .rs1_data(rs1),
    .branch_taken(branch_taken), .branch_source(branch_source),
    .branch_jalr_target(jalr_t), .branch_jal_beq_bne_target(rel_t),
    .pred_taken(pred_taken), .busy(busy),
    .resolve_valid(rv), .resolve_pc(rpc), .resolve_taken(rt),
    .resolve_pred_taken(rpt), .resolve_target(rtgt),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .pred_cnt(pred_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] p, input logic t, input logic pt);
    rv = 1'b1; rpc = p; rt = t; rpt = pt; rtgt = p + 32'd8;
  endtask

  task automatic sweep_count(output int cycles, output logic q);
    cycles = 0;
    q = 1'b1;
    while (busy === 1'b1 && cycles < 4 * DEPTH) begin
      if (branch_taken !== 1'b0 || pred_taken !== 1'b0 || rel_t !== 32'd0) q = 1'b0;
      cycles++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h00408067, 32'h40,       32'h2001, 1'b1, 1'b1, 32'h2004, 32'h0,    1'b0};
    vecs[1] = '{JAL_M8,       32'h10,       32'h0,    1'b1, 1'b0, 32'h0,    32'h8,    1'b0};
    vecs[2] = '{BEQ8,         32'h100,      32'h0,    1'b0, 1'b0, 32'h0,    32'h108,  1'b0};
    vecs[3] = '{32'hFE209EE3, 32'h204,      32'h0,    1'b0, 1'b0, 32'h0,    32'h200,  1'b0};
    vecs[4] = '{BEQ8,         32'hFFFFFFF8, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,    1'b0};
    vecs[5] = '{32'h00500093, 32'h300,      32'h55,   1'b0, 1'b0, 32'h0,    32'h0,    1'b0};
    vecs[6] = '{32'hFFF08067, 32'h0,        32'h1000, 1'b1, 1'b1, 32'hFFE,  32'h0,    1'b0};
    vecs[7] = '{32'h010000EF, 32'h1000,     32'h0,    1'b1, 1'b0, 32'h0,    32'h1010, 1'b0};

    rst_n = 1'b0; start = 1'b0; bht_clear = 1'b0;
    inst = NOP; pc = '0; rs1 = '0;
    rv = 1'b0; rpc = '0; rt = 1'b0; rpt = 1'b0; rtgt = '0;

    // Reset state, and IDLE keeps a jal quiet.
    #12;
    chk("reset busy", busy, 0);
    chk("reset pred_cnt", pred_cnt, 0);
    chk("reset mispred_cnt", mispred_cnt, 0);
    rst_n = 1'b1; inst = JAL_M8; pc = 32'h10;
    #1;
    chk("idle jal taken", branch_taken, 0);
    step();
    chk("idle jal target", rel_t, 0);

    // Enter ACTIVE, first beq at 0x100.
    start = 1'b1; inst = NOP;
    step();
    inst = BEQ8; pc = 32'h100;
    #1;
    chk("beq0 taken", branch_taken, 0);
    chk("beq0 pred", pred_taken, 0);
    chk("beq0 target", rel_t, 32'h108);
    chk("beq0 source", branch_source, 0);
    step(); exp_pc++;
    inst = NOP;
    #1;
    chk("pred_cnt after beq0", pred_cnt, exp_pc);

    // Decode table on a freshly reset BHT.
    for (int i = 0; i < 8; i++) begin
      inst = vecs[i].inst; pc = vecs[i].pc; rs1 = vecs[i].rs1;
      #1;
      chk($sformatf("vec%0d taken", i), branch_taken, vecs[i].taken);
      chk($sformatf("vec%0d source", i), branch_source, vecs[i].src);
      chk($sformatf("vec%0d jalr_target", i), jalr_t, vecs[i].jalr_t);
      chk($sformatf("vec%0d rel_target", i), rel_t, vecs[i].rel_t);
      chk($sformatf("vec%0d pred", i), pred_taken, vecs[i].pred);
      step();
      if (vecs[i].inst[6:0] == 7'b1100011) exp_pc++;
    end
    inst = NOP;
    #1;
    chk("pred_cnt after table", pred_cnt, exp_pc);

    // Two taken resolutions predicted not-taken: 01 -> 10 -> 11.
    for (int k = 0; k < 2; k++) begin
      resolve(32'h100, 1'b1, 1'b0);
      #1;
      chk($sformatf("res%0d mispredict", k), mispredict, 1);
      chk($sformatf("res%0d redirect", k), redirect_pc, 32'h108);
      step(); exp_mc++;
    end
    rv = 1'b0;
    #1;
    chk("mispred_cnt after 2", mispred_cnt, exp_mc);
    inst = BEQ8; pc = 32'h100;
    #1;
    chk("trained beq taken", branch_taken, 1);
    step(); exp_pc++;
    inst = NOP;

    // Three more taken: counter must hold at 11.
    for (int k = 0; k < 3; k++) begin
      resolve(32'h100, 1'b1, 1'b1);
      #1;
      if (k == 0) begin
        chk("correct pred mispredict", mispredict, 0);
        chk("correct pred redirect", redirect_pc, 0);
      end
      step();
    end
    resolve(32'h100, 1'b0, 1'b1);
    #1;
    chk("nt mispredict", mispredict, 1);
    chk("nt redirect", redirect_pc, 32'h104);
    step(); exp_mc++;
    rv = 1'b0; inst = BEQ8; pc = 32'h100;
    #1;
    chk("after 1 nt pred", pred_taken, 1);
    step(); exp_pc++;
    inst = NOP;
    resolve(32'h100, 1'b0, 1'b1);
    step(); exp_mc++;
    rv = 1'b0; inst = BEQ8; pc = 32'h100;
    #1;
    chk("after 2 nt pred", pred_taken, 0);
    step(); exp_pc++;

    // Same-cycle decode and update at the same index: no bypass.
    resolve(32'h100, 1'b1, 1'b0);
    #1;
    chk("same cycle pred", pred_taken, 0);
    step(); exp_pc++; exp_mc++;
    rv = 1'b0;
    #1;
    chk("next cycle pred", pred_taken, 1);
    step(); exp_pc++;
    inst = NOP;
    #1;
    chk("pred_cnt mid", pred_cnt, exp_pc);
    chk("mispred_cnt mid", mispred_cnt, exp_mc);

    // IDLE: mispredict still reported and BHT updated, but not counted.
    start = 1'b0;
    step();
    resolve(32'h100, 1'b0, 1'b1);
    #1;
    chk("idle mispredict", mispredict, 1);
    chk("idle redirect", redirect_pc, 32'h104);
    step();
    rv = 1'b0;
    #1;
    chk("idle mispred_cnt", mispred_cnt, exp_mc);
    start = 1'b1;
    step();
    inst = BEQ8; pc = 32'h100;
    #1;
    chk("idle update applied", pred_taken, 0);
    step(); exp_pc++;
    inst = NOP;

    // Train index 0 and the last index to strongly taken before clearing.
    for (int k = 0; k < 2; k++) begin resolve(32'hFC, 1'b1, 1'b1); step(); end
    for (int k = 0; k < 2; k++) begin resolve(32'h100, 1'b1, 1'b1); step(); end
    rv = 1'b0; inst = BEQ8; pc = 32'hFC;
    #1;
    chk("last idx trained", pred_taken, 1);
    inst = NOP;

    // Clear sweep with a B-type and updates applied throughout.
    bht_clear = 1'b1;
    step();
    bht_clear = 1'b0; inst = BEQ8; pc = 32'h100;
    resolve(32'h100, 1'b1, 1'b1);
    #1;
    chk("init busy", busy, 1);
    sweep_count(n, quiet);
    chk("busy cycles", n, DEPTH);
    chk("init outputs quiet", quiet, 1);
    rv = 1'b0;
    #1;
    chk("post sweep busy", busy, 0);
    chk("post sweep idx0 pred", pred_taken, 0);
    chk("post sweep active target", rel_t, 32'h108);
    chk("pred_cnt held in init", pred_cnt, exp_pc);
    pc = 32'hFC;
    #1;
    chk("post sweep last idx", pred_taken, 0);
    inst = NOP;

    // Clear request inside INIT restarts the sweep.
    bht_clear = 1'b1;
    step();
    bht_clear = 1'b0;
    repeat (5) step();
    bht_clear = 1'b1;
    step();
    bht_clear = 1'b0;
    sweep_count(n, quiet);
    chk("restart busy cycles", n, DEPTH);

    // Reset in the middle of a sweep.
    bht_clear = 1'b1;
    step();
    bht_clear = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid sweep reset busy", busy, 0);
    chk("mid sweep reset pred_cnt", pred_cnt, 0);
    exp_pc = 0; exp_mc = 0;
    step();
    rst_n = 1'b1;
    step();
    inst = BEQ8; pc = 32'h100;
    #1;
    chk("after reset active", branch_taken, 0);
    chk("after reset target", rel_t, 32'h108);

    // Statistics saturation.
    repeat (40) step();
    chk("pred_cnt saturates", pred_cnt, 31);
    inst = NOP;
    resolve(32'h40, 1'b1, 1'b0);
    repeat (40) step();
    chk("mispred_cnt saturates", mispred_cnt, 31);
    rv = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
